// File: rtl/prod_serializer_pkg.sv
// Shared types and helpers for the product serializer and the multiplier
// array that feeds it.
package prod_serializer_pkg;

   // Default product geometry, shared with the multiplier array.
   localparam int unsigned DEF_DATA_W = 19;
   localparam int unsigned DEF_LANES  = 4;

   // Serializer control states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   // Index width for n entries; never narrower than one bit.
   function automatic int unsigned lane_w(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prod_serializer_if.sv
// Handshake bundle for the product serializer: a frame-wide input side and
// a one-product-per-beat output side, each with valid/ready.
interface prod_serializer_if
   import prod_serializer_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned LANES  = DEF_LANES
);
   localparam int unsigned LW = lane_w(LANES);

   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       out_data;
   logic [LW-1:0]           out_lane;
   logic                    out_last;

   // Environment side: offers frames and sinks products.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_lane, out_last
   );

   // Serializer side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_lane, out_last
   );
endinterface

// File: rtl/prod_serializer.sv
// Parallel-to-serial product buffer: captures LANES products in one beat and
// replays them one per accepted beat, followed by a programmable idle gap.
module prod_serializer
   import prod_serializer_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned LANES      = DEF_LANES,   // must be at least 2
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned REVERSE    = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   prod_serializer_if.slave        bus,
   output logic                    busy
);
   localparam int unsigned LW      = lane_w(LANES);
   localparam int unsigned GW      = lane_w((GAP_CYCLES > 32'd1) ? GAP_CYCLES : 32'd2);
   localparam bit          REV     = (REVERSE != 32'd0);
   localparam int unsigned FIRST_I = REV ? (LANES - 32'd1) : 32'd0;
   localparam logic [LW-1:0] FIRST = LW'(FIRST_I);
   localparam logic [LW-1:0] FINAL = REV ? LW'(0) : LW'(LANES - 32'd1);
   localparam logic [LW-1:0] ONE   = LW'(1);
   localparam logic [GW-1:0] GONE  = GW'(1);
   localparam logic [GW-1:0] GLOAD = GW'(GAP_CYCLES - 32'd1);

   state_e            state_q;
   logic [DATA_W-1:0] hold_q [LANES];
   logic [GW-1:0]     gap_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [LW-1:0]     out_lane_q;
   logic              out_last_q;
   logic              busy_q;

   logic [LW-1:0]     idx_d;
   logic              in_ready_s;
   logic              take_s;
   logic              fire_s;

   // Next lane index and handshake qualifiers. With no gap, the final beat of
   // a frame also accepts the next frame so the output never bubbles.
   always_comb begin
      idx_d      = REV ? (out_lane_q - ONE) : (out_lane_q + ONE);
      in_ready_s = 1'b0;
      if (state_q == IDLE) begin
         in_ready_s = 1'b1;
      end else if ((GAP_CYCLES == 32'd0) && (state_q == SHIFT)) begin
         in_ready_s = out_last_q & bus.out_ready;
      end else begin
         in_ready_s = 1'b0;
      end
      take_s = bus.in_valid & in_ready_s;
      fire_s = out_valid_q & bus.out_ready;
   end

   // Control FSM, hold-register file and registered output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gap_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_lane_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < int'(LANES); i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         if (take_s) begin
            for (int i = 0; i < int'(LANES); i++) begin
               hold_q[i] <= bus.in_data[i*int'(DATA_W) +: DATA_W];
            end
         end
         case (state_q)
            IDLE: begin
               if (take_s) begin
                  // First lane comes straight from the bus so it shows next cycle.
                  state_q     <= SHIFT;
                  out_valid_q <= 1'b1;
                  out_lane_q  <= FIRST;
                  out_data_q  <= bus.in_data[FIRST_I*DATA_W +: DATA_W];
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            SHIFT: begin
               if (fire_s) begin
                  if (out_last_q) begin
                     out_last_q <= 1'b0;
                     if (GAP_CYCLES == 32'd0) begin
                        if (take_s) begin
                           out_valid_q <= 1'b1;
                           out_lane_q  <= FIRST;
                           out_data_q  <= bus.in_data[FIRST_I*DATA_W +: DATA_W];
                        end else begin
                           state_q     <= IDLE;
                           out_valid_q <= 1'b0;
                           busy_q      <= 1'b0;
                        end
                     end else begin
                        state_q     <= GAP;
                        gap_q       <= GLOAD;
                        out_valid_q <= 1'b0;
                     end
                  end else begin
                     out_lane_q <= idx_d;
                     out_data_q <= hold_q[idx_d];
                     out_last_q <= (idx_d == FINAL);
                  end
               end
            end
            GAP: begin
               if (gap_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q - GONE;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_lane  = out_lane_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_prod_serializer.sv
// Randomized scoreboard bench for prod_serializer: one default instance
// (4x19, gap 4, forward) and one (8x24, no gap, reversed).
module tb_prod_serializer;

   typedef struct {
      logic [31:0] data;
      int          lane;
      logic        last;
   } exp_t;

   logic clk;
   logic reset;
   logic busy_a, busy_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   rnd    = 1'b0;
   exp_t q_exp [2][$];
   int   ready_at [2];

   prod_serializer_if #(.DATA_W(19), .LANES(4)) bus_a ();
   prod_serializer_if #(.DATA_W(24), .LANES(8)) bus_b ();

   prod_serializer #(.DATA_W(19), .LANES(4), .GAP_CYCLES(4), .REVERSE(0)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a)
   );
   prod_serializer #(.DATA_W(24), .LANES(8), .GAP_CYCLES(0), .REVERSE(1)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used by the gap-timing model.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model step for one instance, evaluated between clock edges.
   task automatic mon(input int d, input int lanes, input int gap, input int rev, input int dw,
                      input logic vld, input logic ordy, input logic [31:0] dat,
                      input logic [31:0] lane, input logic last, input logic ivld,
                      input logic irdy, input logic bsy, input logic [191:0] idata);
      logic  exp_irdy;
      exp_t  e;
      logic [191:0] sh;
      logic [191:0] mask;
      string p;
      p = (d == 0) ? "a" : "b";
      if (reset) begin
         chk({p, "_rst_valid"}, 64'(vld), 64'd0);
         chk({p, "_rst_data"}, 64'(dat), 64'd0);
         chk({p, "_rst_lane"}, 64'(lane), 64'd0);
         chk({p, "_rst_last"}, 64'(last), 64'd0);
         chk({p, "_rst_busy"}, 64'(bsy), 64'd0);
         q_exp[d].delete();
         ready_at[d] = 0;
         return;
      end
      exp_irdy = ((q_exp[d].size() == 0) && (cyc >= ready_at[d])) ||
                 ((gap == 0) && (q_exp[d].size() == 1) && (ordy == 1'b1));
      chk({p, "_in_ready"}, 64'(irdy), 64'(exp_irdy));
      chk({p, "_busy"}, 64'(bsy), 64'((q_exp[d].size() != 0) || (cyc < ready_at[d])));
      chk({p, "_out_valid"}, 64'(vld), 64'(q_exp[d].size() != 0));
      if ((q_exp[d].size() != 0) && (vld === 1'b1)) begin
         chk({p, "_data"}, 64'(dat), 64'(q_exp[d][0].data));
         chk({p, "_lane"}, 64'(lane), 64'(q_exp[d][0].lane));
         chk({p, "_last"}, 64'(last), 64'(q_exp[d][0].last));
         if (ordy === 1'b1) begin
            if (q_exp[d][0].last) ready_at[d] = cyc + 1 + gap;
            void'(q_exp[d].pop_front());
         end
      end
      if ((ivld === 1'b1) && (irdy === 1'b1)) begin
         mask = (192'd1 << dw) - 192'd1;
         for (int k = 0; k < lanes; k++) begin
            e.lane = (rev != 0) ? (lanes - 1 - k) : k;
            sh     = (idata >> (e.lane * dw)) & mask;
            e.data = sh[31:0];
            e.last = (k == lanes - 1);
            q_exp[d].push_back(e);
         end
      end
   endtask

   // Scoreboard monitors, sampling mid-cycle.
   always @(negedge clk) begin
      mon(0, 4, 4, 0, 19, bus_a.out_valid, bus_a.out_ready, 32'(bus_a.out_data),
          32'(bus_a.out_lane), bus_a.out_last, bus_a.in_valid, bus_a.in_ready, busy_a,
          192'(bus_a.in_data));
   end

   always @(negedge clk) begin
      mon(1, 8, 0, 1, 24, bus_b.out_valid, bus_b.out_ready, 32'(bus_b.out_data),
          32'(bus_b.out_lane), bus_b.out_last, bus_b.in_valid, bus_b.in_ready, busy_b,
          192'(bus_b.in_data));
   end

   // Random back-pressure on both output sides when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd) begin
            bus_a.out_ready = 1'($urandom_range(0, 1));
            bus_b.out_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Offer one frame and hold it until accepted (bounded).
   task automatic send(input int d, input logic [191:0] data);
      bit done;
      done = 1'b0;
      if (d == 0) begin
         bus_a.in_data  = data[75:0];
         bus_a.in_valid = 1'b1;
      end else begin
         bus_b.in_data  = data[191:0];
         bus_b.in_valid = 1'b1;
      end
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         if (((d == 0) ? bus_a.in_ready : bus_b.in_ready) === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
      if (d == 0) bus_a.in_valid = 1'b0;
      else        bus_b.in_valid = 1'b0;
   endtask

   // Wait until an instance has drained and left its gap (bounded).
   task automatic wait_idle(input int d);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         if ((q_exp[d].size() == 0) && (((d == 0) ? busy_a : busy_b) === 1'b0)) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [191:0] rand_frame();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [191:0] f;
      ready_at[0] = 0;
      ready_at[1] = 0;
      reset = 1'b1;
      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // Basic frame with the sink always ready, then gap timing.
      bus_a.out_ready = 1'b1;
      f = 192'({19'h00044, 19'h00033, 19'h00022, 19'h00011});
      send(0, f);
      wait_idle(0);

      // Same frame with a 3-cycle stall while lane 1 is presented.
      send(0, f);
      @(posedge clk);
      #1 bus_a.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus_a.out_ready = 1'b1;
      wait_idle(0);

      // All-ones products pass through unchanged.
      send(0, 192'({4{19'h7FFFF}}));
      wait_idle(0);

      // Reversed 8-lane instance, lanes 1..8.
      bus_b.out_ready = 1'b1;
      f = '0;
      for (int i = 0; i < 8; i++) f[i*24 +: 24] = 24'(i + 1);
      send(1, f);
      wait_idle(1);

      // Back-to-back frames with in_valid held: no bubble between them.
      for (int i = 0; i < 8; i++) f[i*24 +: 24] = 24'h00A000 + 24'(i);
      send(1, f);
      for (int i = 0; i < 8; i++) f[i*24 +: 24] = 24'h00B000 + 24'(i);
      send(1, f);
      wait_idle(1);

      // Reset after lane 1 has been consumed: remaining lanes are dropped.
      send(0, 192'({19'h00044, 19'h00033, 19'h00022, 19'h00011}));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Randomized frames under random back-pressure.
      rnd = 1'b1;
      for (int i = 0; i < 15; i++) send(0, rand_frame());
      for (int i = 0; i < 15; i++) send(1, rand_frame());
      wait_idle(0);
      wait_idle(1);
      rnd = 1'b0;
      @(posedge clk);
      #2;
      bus_a.out_ready = 1'b1;
      bus_b.out_ready = 1'b1;
      repeat (4) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
